// File: rtl/fft_seq_core.sv
// Frame-based radix-2 DIT FFT with a single time-multiplexed butterfly.
// Samples load bit-reversed into a register RAM, are transformed in place, then stream out in natural order.
module fft_seq_core #(
    parameter int WIDTH   = 16,
    parameter int LOG2N   = 4,
    parameter int TW_FRAC = 14,
    parameter int SCALE   = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] in_re,
    input  logic signed [WIDTH-1:0] in_im,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] out_re,
    output logic signed [WIDTH-1:0] out_im,
    output logic [LOG2N-1:0]        out_index,
    output logic                    out_last,
    output logic                    busy,
    output logic                    ovf
);
    localparam int N   = 1 << LOG2N;
    localparam int TWW = TW_FRAC + 2;
    localparam int SW  = WIDTH + 2;
    localparam int PW  = WIDTH + TWW + 1;
    localparam int RND = 1 << (TW_FRAC - 1);
    localparam logic signed [WIDTH-1:0] MAXV = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {LOAD, COMPUTE, OUTPUT} state_e;

    state_e             state_q, state_d;
    logic [LOG2N-1:0]   cnt_q, cnt_d;
    logic [LOG2N-2:0]   bfly_q, bfly_d;
    logic [2:0]         stage_q, stage_d;
    logic               ovf_q, ovf_d;

    logic signed [WIDTH-1:0] ramRe [N];
    logic signed [WIDTH-1:0] ramIm [N];
    logic signed [TWW-1:0]   twRe [N/2];
    logic signed [TWW-1:0]   twIm [N/2];

    function automatic int twCoef(input int k, input bit imagPart);
        real ang;
        real v;
        ang = 2.0 * 3.14159265358979323846 * real'(k) / real'(N);
        v = imagPart ? -$sin(ang) : $cos(ang);
        v = v * real'(1 << TW_FRAC);
        if (!imagPart && k == 0) return (1 << TW_FRAC) - 1;
        return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
    endfunction

    function automatic logic [LOG2N-1:0] bitRev(input logic [LOG2N-1:0] v);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) r[i] = v[LOG2N-1-i];
        return r;
    endfunction

    // Optional rounded halving, then clamp; MSB of the result flags a clamp.
    function automatic logic [WIDTH:0] scaleSat(input logic signed [SW-1:0] x);
        logic signed [SW-1:0] y;
        y = (SCALE != 0) ? ((x + SW'(1)) >>> 1) : x;
        if (y > SW'(MAXV)) return {1'b1, MAXV};
        if (y < SW'(MINV)) return {1'b1, MINV};
        return {1'b0, y[WIDTH-1:0]};
    endfunction

    for (genvar k = 0; k < N/2; k++) begin : gTw
        localparam int TRE = twCoef(k, 1'b0);
        localparam int TIM = twCoef(k, 1'b1);
        assign twRe[k] = TWW'(TRE);
        assign twIm[k] = TWW'(TIM);
    end

    logic [LOG2N-1:0]        half, pos, group, bflyExt, addrA, addrB;
    logic [LOG2N-2:0]        twIdx;
    logic signed [WIDTH-1:0] aRe, aIm, bRe, bIm;
    logic signed [TWW-1:0]   wRe, wIm;
    logic signed [PW-1:0]    pRe, pIm, rRe, rIm;
    logic signed [SW-1:0]    tRe, tIm;
    logic [WIDTH:0]          sumRe, sumIm, difRe, difIm;
    logic                    bfSat;

    always_comb begin
        bflyExt = {1'b0, bfly_q};
        half    = LOG2N'(1) << stage_q;
        pos     = bflyExt & (half - LOG2N'(1));
        group   = bflyExt >> stage_q;
        addrA   = (group << (stage_q + 3'd1)) | pos;
        addrB   = addrA | half;
        twIdx   = (LOG2N-1)'(pos << (LOG2N - 1 - stage_q));
        aRe = ramRe[addrA];
        aIm = ramIm[addrA];
        bRe = ramRe[addrB];
        bIm = ramIm[addrB];
        wRe = twRe[twIdx];
        wIm = twIm[twIdx];
        pRe = PW'(bRe) * PW'(wRe) - PW'(bIm) * PW'(wIm);
        pIm = PW'(bRe) * PW'(wIm) + PW'(bIm) * PW'(wRe);
        rRe = (pRe + PW'(RND)) >>> TW_FRAC;
        rIm = (pIm + PW'(RND)) >>> TW_FRAC;
        tRe = SW'(rRe);
        tIm = SW'(rIm);
        sumRe = scaleSat(SW'(aRe) + tRe);
        sumIm = scaleSat(SW'(aIm) + tIm);
        difRe = scaleSat(SW'(aRe) - tRe);
        difIm = scaleSat(SW'(aIm) - tIm);
        bfSat = sumRe[WIDTH] | sumIm[WIDTH] | difRe[WIDTH] | difIm[WIDTH];
    end

    // cnt_q counts loaded samples in LOAD and presented bins in OUTPUT.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bfly_d  = bfly_q;
        stage_d = stage_q;
        ovf_d   = ovf_q;
        case (state_q)
            LOAD: begin
                if (in_valid) begin
                    cnt_d = cnt_q + LOG2N'(1);
                    if (cnt_q == '0) ovf_d = 1'b0;
                    if (cnt_q == '1) state_d = COMPUTE;
                end
            end
            COMPUTE: begin
                if (bfSat) ovf_d = 1'b1;
                bfly_d = bfly_q + 1'b1;
                if (bfly_q == '1) begin
                    stage_d = stage_q + 3'd1;
                    if (stage_q == 3'(LOG2N - 1)) begin
                        stage_d = '0;
                        state_d = OUTPUT;
                    end
                end
            end
            OUTPUT: begin
                if (out_ready) begin
                    cnt_d = cnt_q + LOG2N'(1);
                    if (cnt_q == '1) state_d = LOAD;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LOAD;
            cnt_q   <= '0;
            bfly_q  <= '0;
            stage_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bfly_q  <= bfly_d;
            stage_q <= stage_d;
            ovf_q   <= ovf_d;
        end
    end

    // Working RAM needs no reset: every frame fully overwrites it during LOAD.
    always_ff @(posedge clk) begin
        if (state_q == LOAD && in_valid) begin
            ramRe[bitRev(cnt_q)] <= in_re;
            ramIm[bitRev(cnt_q)] <= in_im;
        end else if (state_q == COMPUTE) begin
            ramRe[addrA] <= sumRe[WIDTH-1:0];
            ramIm[addrA] <= sumIm[WIDTH-1:0];
            ramRe[addrB] <= difRe[WIDTH-1:0];
            ramIm[addrB] <= difIm[WIDTH-1:0];
        end
    end

    assign in_ready  = (state_q == LOAD);
    assign out_valid = (state_q == OUTPUT);
    assign busy      = (state_q != LOAD);
    assign ovf       = ovf_q;
    assign out_index = out_valid ? cnt_q : '0;
    assign out_last  = out_valid && (cnt_q == '1);
    assign out_re    = out_valid ? ramRe[cnt_q] : '0;
    assign out_im    = out_valid ? ramIm[cnt_q] : '0;

endmodule

// File: tb/tb_fft_seq_core.sv
// Directed bench for fft_seq_core at N=16: one unscaled and one scaled instance share the same stimulus.
module tb_fft_seq_core;
    localparam int WIDTH = 16;
    localparam int LOG2N = 4;
    localparam int N     = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic inValid = 1'b0;
    logic outReady = 1'b0;
    logic signed [WIDTH-1:0] inRe = '0;
    logic signed [WIDTH-1:0] inIm = '0;

    logic inReady0, outValid0, outLast0, busy0, ovf0;
    logic inReady1, outValid1, outLast1, busy1, ovf1;
    logic signed [WIDTH-1:0] outRe0, outIm0, outRe1, outIm1;
    logic [LOG2N-1:0] outIndex0, outIndex1;

    fft_seq_core #(.WIDTH(WIDTH), .LOG2N(LOG2N), .TW_FRAC(14), .SCALE(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady0),
        .in_re(inRe), .in_im(inIm), .out_valid(outValid0), .out_ready(outReady),
        .out_re(outRe0), .out_im(outIm0), .out_index(outIndex0), .out_last(outLast0),
        .busy(busy0), .ovf(ovf0)
    );

    fft_seq_core #(.WIDTH(WIDTH), .LOG2N(LOG2N), .TW_FRAC(14), .SCALE(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady1),
        .in_re(inRe), .in_im(inIm), .out_valid(outValid1), .out_ready(outReady),
        .out_re(outRe1), .out_im(outIm1), .out_index(outIndex1), .out_last(outLast1),
        .busy(busy1), .ovf(ovf1)
    );

    always #5 clk = ~clk;

    int testsRun = 0;
    int testsFailed = 0;
    int stimRe [N];
    int stimIm [N];
    int binRe0 [N];
    int binIm0 [N];
    int binRe1 [N];
    int binIm1 [N];
    int computeCycles;
    bit readyLeak;
    int ovfAfterFirst;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic checkNear(input string tag, input int observed, input int expected);
        testsRun++;
        assert (observed >= expected - 1 && observed <= expected + 1) else begin
            testsFailed++;
            $error("[TB] FAIL %s observed=%0d expected=%0d(+-1)", tag, observed, expected);
        end
    endtask

    task automatic setFrame(input int evenRe, input int oddRe, input bit impulse);
        for (int i = 0; i < N; i++) begin
            stimRe[i] = impulse ? ((i == 0) ? evenRe : 0) : ((i % 2 == 0) ? evenRe : oddRe);
            stimIm[i] = 0;
        end
    endtask

    // Streams one frame; holdValid keeps in_valid asserted afterwards to probe in_ready.
    task automatic applyStimulus(input bit holdValid);
        for (int i = 0; i < N; i++) begin
            inValid = 1'b1;
            inRe = 16'(stimRe[i]);
            inIm = 16'(stimIm[i]);
            @(posedge clk); #1;
            if (i == 0) ovfAfterFirst = int'(ovf0);
        end
        inValid = holdValid;
    endtask

    task automatic waitCompute();
        computeCycles = 0;
        checkOutput("busyInCompute", busy0, 1);
        while (!outValid0 && computeCycles < 200) begin
            if (inReady0) readyLeak = 1'b1;
            computeCycles++;
            @(posedge clk); #1;
        end
        checkOutput("computeCycles", computeCycles, 32);
    endtask

    task automatic collectBins(input bit backpressure);
        int got = 0;
        int guard = 0;
        int heldIdx = 0;
        int heldRe = 0;
        bit stalled = 1'b0;
        bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        while (got < N && guard < 400) begin
            outReady = backpressure ? pat[guard % 4] : 1'b1;
            guard++;
            if (inReady0) readyLeak = 1'b1;
            if (stalled) begin
                checkOutput("holdIndex", int'(outIndex0), heldIdx);
                checkOutput("holdRe", int'(outRe0), heldRe);
            end
            stalled = 1'b0;
            if (outValid0) begin
                if (outReady) begin
                    checkOutput("binIndex", int'(outIndex0), got);
                    checkOutput("binLast", int'(outLast0), int'(got == N - 1));
                    binRe0[outIndex0] = int'(outRe0);
                    binIm0[outIndex0] = int'(outIm0);
                    binRe1[outIndex1] = int'(outRe1);
                    binIm1[outIndex1] = int'(outIm1);
                    got++;
                end else begin
                    stalled = 1'b1;
                    heldIdx = int'(outIndex0);
                    heldRe = int'(outRe0);
                end
            end
            @(posedge clk); #1;
        end
        outReady = 1'b0;
        checkOutput("binsReceived", got, N);
    endtask

    task automatic checkImpulseBins(input string tag);
        for (int k = 0; k < N; k++) begin
            checkOutput({tag, "Re"}, binRe0[k], 1000);
            checkOutput({tag, "Im"}, binIm0[k], 0);
        end
    endtask

    task automatic runFrame(input bit holdValid, input bit backpressure);
        readyLeak = 1'b0;
        applyStimulus(holdValid);
        waitCompute();
        collectBins(backpressure);
        inValid = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rstInReady", inReady0, 1);
        checkOutput("rstOutValid", outValid0, 0);
        checkOutput("rstOutRe", int'(outRe0), 0);
        checkOutput("rstOutIm", int'(outIm0), 0);
        checkOutput("rstOutIndex", int'(outIndex0), 0);
        checkOutput("rstOutLast", outLast0, 0);
        checkOutput("rstBusy", busy0, 0);
        checkOutput("rstOvf", ovf0, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Impulse, unscaled: flat spectrum of 1000.
        setFrame(1000, 0, 1'b1);
        runFrame(1'b0, 1'b0);
        checkImpulseBins("imp");
        checkOutput("impOvf", ovf0, 0);

        // DC on the scaled instance: only bin 0 is nonzero, exactly 100.
        setFrame(100, 100, 1'b0);
        runFrame(1'b0, 1'b0);
        for (int k = 0; k < N; k++) begin
            checkOutput("dcRe", binRe1[k], (k == 0) ? 100 : 0);
            checkOutput("dcIm", binIm1[k], 0);
        end

        // Alternating sign, unscaled: all energy in bin 8.
        setFrame(200, -200, 1'b0);
        runFrame(1'b0, 1'b0);
        for (int k = 0; k < N; k++) begin
            if (k == 0 || k == 8) begin
                checkOutput("altRe", binRe0[k], (k == 8) ? 3200 : 0);
                checkOutput("altIm", binIm0[k], 0);
            end else begin
                checkNear("altReNear", binRe0[k], 0);
                checkNear("altImNear", binIm0[k], 0);
            end
        end

        // Full-scale DC saturates bin 0 and raises ovf.
        setFrame(32767, 32767, 1'b0);
        runFrame(1'b0, 1'b0);
        checkOutput("satBin0Re", binRe0[0], 32767);
        checkOutput("satBin0Im", binIm0[0], 0);
        checkOutput("satOvf", ovf0, 1);

        // Next frame clears ovf at its first accept.
        setFrame(1000, 0, 1'b1);
        runFrame(1'b0, 1'b0);
        checkOutput("ovfClearedFirstAccept", ovfAfterFirst, 0);
        checkOutput("ovfStaysClear", ovf0, 0);
        checkImpulseBins("impAfterSat");

        // Backpressure with in_valid held high through compute and output.
        setFrame(1000, 0, 1'b1);
        readyLeak = 1'b0;
        applyStimulus(1'b1);
        waitCompute();
        collectBins(1'b1);
        checkOutput("bpInReadyAfterLast", inReady0, 1);
        checkOutput("bpOutValidAfterLast", outValid0, 0);
        checkOutput("bpBusyAfterLast", busy0, 0);
        inValid = 1'b0;
        checkOutput("bpNoEarlyReady", int'(readyLeak), 0);
        checkImpulseBins("bp");

        // Abort mid-compute on a saturating frame.
        setFrame(32767, 32767, 1'b0);
        applyStimulus(1'b0);
        repeat (10) @(posedge clk);
        #1;
        checkOutput("preAbortOvf", ovf0, 1);
        checkOutput("preAbortBusy", busy0, 1);
        rst = 1'b1;
        #1;
        checkOutput("abortInReady", inReady0, 1);
        checkOutput("abortBusy", busy0, 0);
        checkOutput("abortOvf", ovf0, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("postAbortInReady", inReady0, 1);
        checkOutput("postAbortOutValid", outValid0, 0);
        checkOutput("postAbortBusy", busy0, 0);
        checkOutput("postAbortOvf", ovf0, 0);
        setFrame(1000, 0, 1'b1);
        runFrame(1'b0, 1'b0);
        checkImpulseBins("postAbort");

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule

// File: doc/fft_seq_core.md
Name: fft_seq_core

Overview:
- Parametrised successor to the fixed 16-point combinational FFT.
- Streaming, frame-based radix-2 DIT FFT with a single time-multiplexed butterfly, an internal ping-free in-place working RAM and a twiddle ROM.
- Accepts complex samples over a valid/ready input, computes in place, then streams bins in natural order over a valid/ready output.
- Sits between the sample front-end and the spectral post-processing blocks.

Parameters:
- WIDTH, 16, signed two's-complement width of every real/imag sample and bin.
- LOG2N, 4, log2 of FFT size N; legal range 3..6 (N = 8..64).
- TW_FRAC, 14, fractional bits of twiddle coefficients (Q1.TW_FRAC, width TW_FRAC+2).
- SCALE, 1, 1 = rounded divide-by-2 after every stage (output = DFT/N); 0 = no scaling, saturate.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  core accepts a sample this cycle.
- in_re  in  WIDTH  input real part, signed.
- in_im  in  WIDTH  input imag part, signed.
- out_valid  out  1  output bin valid.
- out_ready  in  1  downstream accepts bin.
- out_re  out  WIDTH  bin real part.
- out_im  out  WIDTH  bin imag part.
- out_index  out  LOG2N  bin number k.
- out_last  out  1  high with bin N-1.
- busy  out  1  high in COMPUTE or OUTPUT.
- ovf  out  1  sticky saturation flag for the current frame.

Behaviour:
- Reset:
  - State is LOAD and all counters are 0.
  - in_ready=1; out_valid=0, out_re=0, out_im=0, out_index=0, out_last=0, busy=0, ovf=0.
  - RAM contents are don't-care.
- FSM: LOAD -> COMPUTE -> OUTPUT -> LOAD.
- LOAD:
  - in_ready=1. Each in_valid&&in_ready stores the sample at bit-reverse(sample_cnt) and increments sample_cnt.
  - The first accept of a frame clears ovf.
  - On the accept with sample_cnt==N-1, move to COMPUTE next cycle; in_ready=0 from that cycle.
- COMPUTE:
  - Exactly one butterfly per cycle: N/2 butterflies per stage, LOG2N stages, N/2*LOG2N cycles total (32 for N=16).
  - Stage s (0..LOG2N-1), butterfly j:
    - half = 2^s, group = j>>s, pos = j & (half-1).
    - Address a = group*2*half + pos, b = a + half.
    - Twiddle index = pos << (LOG2N-1-s), with W^k = cos(2*pi*k/N) - j*sin(2*pi*k/N).
  - Read and write happen in the same cycle (register-array RAM).
  - The twiddle ROM is computed at elaboration; entries are rounded to nearest and W^0 real = 2^TW_FRAC - 1.
  - After the last butterfly, move to OUTPUT.
- Butterfly arithmetic:
  - t = B*W using full-precision products.
  - t_re and t_im are each rounded as (p + 2^(TW_FRAC-1)) >>> TW_FRAC.
  - Form A+t and A-t at WIDTH+2 bits.
  - SCALE=1: result = (x+1) >>> 1, then saturate to WIDTH.
  - SCALE=0: saturate to WIDTH.
  - Any saturation sets ovf (sticky until the next frame's first accept).
- OUTPUT:
  - out_valid=1; out_re/out_im = RAM[out_index]; out_index starts at 0.
  - On out_valid&&out_ready, out_index increments.
  - While out_ready=0, all out_* hold stable.
  - out_last=1 when out_index==N-1. Its transfer returns the FSM to LOAD: out_valid=0 and in_ready=1 on the next cycle.
- busy = (state != LOAD).
- in_valid outside LOAD is ignored (in_ready=0). No sample is lost or duplicated.
- Frame throughput: N load + N*LOG2N/2 compute + N output cycles minimum; load and output do not overlap.
- Reset asserted mid-COMPUTE or mid-OUTPUT aborts the frame immediately, with all outputs at reset values. The first sample after reset is sample 0 of a new frame.

Test Plan:
- Impulse, SCALE=0, N=16: in_re = 1000 at n=0, else 0; all im=0 -> all 16 bins re=1000, im=0; ovf=0; out_last only with index 15.
- DC, SCALE=1: all 16 samples re=100, im=0 -> bin0 re=100, im=0; bins 1..15 re=0, im=0 (exact, no rounding error).
- Alternating sign, SCALE=0: x[n] = +200/-200 -> bin8 re=3200, im=0; all others 0 (±1 tolerance on bins using non-trivial twiddles).
- Overflow, SCALE=0: all samples re=32767 -> bin0 re=32767 (saturated), ovf=1. Next frame of impulse 1000 -> ovf cleared at its first accept and stays 0.
- Backpressure: out_ready toggled 1,0,0,1 repeatedly, and in_valid driven during COMPUTE -> each bin is presented until accepted, index sequence is 0..15 with no gaps, in_ready stays 0 until after the out_last transfer, and compute is exactly 32 cycles.
- Reset mid-COMPUTE (cycle 10) -> next cycle in_ready=1, out_valid=0, busy=0, ovf=0. A following impulse frame yields the correct all-1000 spectrum.
